fullscreen_sequencer: RTL and testbench

//  Schedules full-screen image overlays (lose, win, title) on the VGA path.

---
 rtl/fullscreen_pkg.sv | 42 ++++
 rtl/fullscreen_req_arb.sv | 43 ++++
 rtl/fullscreen_sequencer.sv | 142 ++++++++++++++
 tb/tb_fullscreen_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fullscreen_pkg.sv
// Shared types for the full-screen overlay path: screen codes, sequencer states, fade range.
package fullscreen_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned FADE_W = 4;
    localparam int unsigned REQ_N  = 3;

    localparam logic [FADE_W-1:0] FADE_MAX = 4'd15;

    typedef enum logic [SEL_W-1:0] {
        SCR_NONE  = 2'd0,
        SCR_TITLE = 2'd1,
        SCR_WIN   = 2'd2,
        SCR_LOSE  = 2'd3
    } screen_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        HOLD     = 2'd2,
        FADE_OUT = 2'd3
    } seq_state_e;

    // One-hot pending-vector bit for a screen: bit0 title, bit1 win, bit2 lose.
    function automatic logic [REQ_N-1:0] screen_mask(input screen_e s);
        case (s)
            SCR_TITLE: screen_mask = 3'b001;
            SCR_WIN:   screen_mask = 3'b010;
            SCR_LOSE:  screen_mask = 3'b100;
            default:   screen_mask = 3'b000;
        endcase
    endfunction

    // Fixed priority lose > win > title.
    function automatic screen_e pick_screen(input logic [REQ_N-1:0] pend);
        if (pend[2])      pick_screen = SCR_LOSE;
        else if (pend[1]) pick_screen = SCR_WIN;
        else if (pend[0]) pick_screen = SCR_TITLE;
        else              pick_screen = SCR_NONE;
    endfunction

endpackage

// File: rtl/fullscreen_req_arb.sv
// Sticky request latch and priority pick for overlay screens; a request arriving in the
// same cycle is already visible to the pick, and requests for the running screen are dropped.
module fullscreen_req_arb
    import fullscreen_pkg::*;
(
    input  logic    vga_clk,
    input  logic    Reset,
    input  logic    lose_req,
    input  logic    win_req,
    input  logic    title_req,
    input  logic    running,
    input  screen_e running_sel,
    input  logic    clr,
    input  screen_e clr_sel,
    output logic    any_pending_c,
    output logic    lose_pending_c,
    output screen_e winner_c
);

    logic [REQ_N-1:0] pend_q;
    logic [REQ_N-1:0] req_vec;
    logic [REQ_N-1:0] drop_vec;
    logic [REQ_N-1:0] eff_c;
    logic [REQ_N-1:0] clr_vec;

    assign req_vec = {lose_req, win_req, title_req};

    always_comb begin
        drop_vec = running ? screen_mask(running_sel) : '0;
        clr_vec  = clr ? screen_mask(clr_sel) : '0;
        eff_c    = pend_q | (req_vec & ~drop_vec);
    end

    assign any_pending_c  = |eff_c;
    assign lose_pending_c = eff_c[2];
    assign winner_c       = pick_screen(eff_c);

    always_ff @(posedge vga_clk) begin
        if (Reset) pend_q <= '0;
        else       pend_q <= eff_c & ~clr_vec;
    end

endmodule

// File: rtl/fullscreen_sequencer.sv
// Frame-synchronous fade-in / hold / fade-out sequencer for full-screen overlays.
// All visible changes land on frame_tick cycles so the renderer never tears mid-frame.
module fullscreen_sequencer
    import fullscreen_pkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES      = 180,
    parameter int unsigned CNT_W            = 8
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              lose_req,
    input  logic              win_req,
    input  logic              title_req,
    input  logic              skip,
    output logic              screen_active,
    output logic [SEL_W-1:0]  screen_sel,
    output logic [FADE_W-1:0] fade,
    output logic              game_pause,
    output logic              seq_done
);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FADE_STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FADE_W-1:0] fade_q, fade_d;
    screen_e           sel_q, sel_d;
    logic              active_q, active_d;
    logic              pause_q, pause_d;
    logic              done_q, done_d;
    logic              start_c;

    logic              any_pending_c;
    logic              lose_pending_c;
    screen_e           winner_c;

    fullscreen_req_arb u_arb (
        .vga_clk        (vga_clk),
        .Reset          (Reset),
        .lose_req       (lose_req),
        .win_req        (win_req),
        .title_req      (title_req),
        .running        (state_q != IDLE),
        .running_sel    (sel_q),
        .clr            (start_c),
        .clr_sel        (winner_c),
        .any_pending_c  (any_pending_c),
        .lose_pending_c (lose_pending_c),
        .winner_c       (winner_c)
    );

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fade_q   <= '0;
            sel_q    <= SCR_NONE;
            active_q <= 1'b0;
            pause_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fade_q   <= fade_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            pause_q  <= pause_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fade_d   = fade_q;
        sel_d    = sel_q;
        active_d = active_q;
        pause_d  = pause_q;
        done_d   = 1'b0;
        start_c  = 1'b0;

        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (any_pending_c) begin
                        state_d  = FADE_IN;
                        sel_d    = winner_c;
                        fade_d   = '0;
                        active_d = 1'b1;
                        pause_d  = 1'b1;
                        cnt_d    = '0;
                        start_c  = 1'b1;
                    end
                end
                FADE_IN: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d  = '0;
                        fade_d = fade_q + 4'd1;
                        if (fade_q == FADE_MAX - 4'd1) state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // A pending lose cuts a win/title overlay short; lose itself stays pending.
                    if (cnt_q == HOLD_LAST || skip || (lose_pending_c && sel_q != SCR_LOSE)) begin
                        state_d = FADE_OUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FADE_OUT: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d  = '0;
                        fade_d = fade_q - 4'd1;
                        if (fade_q == 4'd1) begin
                            state_d  = IDLE;
                            sel_d    = SCR_NONE;
                            active_d = 1'b0;
                            pause_d  = any_pending_c;
                            done_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign screen_active = active_q;
    assign screen_sel    = sel_q;
    assign fade          = fade_q;
    assign game_pause    = pause_q;
    assign seq_done      = done_q;

endmodule

// File: tb/tb_fullscreen_sequencer.sv
// Directed bench for fullscreen_sequencer: a per-cycle vector table plus multi-frame sequences.
module tb_fullscreen_sequencer;

    logic       vga_clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       lose_req;
    logic       win_req;
    logic       title_req;
    logic       skip;
    logic       screen_active;
    logic [1:0] screen_sel;
    logic [3:0] fade;
    logic       game_pause;
    logic       seq_done;

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    fullscreen_sequencer dut (
        .vga_clk       (vga_clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .lose_req      (lose_req),
        .win_req       (win_req),
        .title_req     (title_req),
        .skip          (skip),
        .screen_active (screen_active),
        .screen_sel    (screen_sel),
        .fade          (fade),
        .game_pause    (game_pause),
        .seq_done      (seq_done)
    );

    typedef struct {
        logic       rst;
        logic       tick;
        logic       lose;
        logic       win;
        logic       title;
        logic       skp;
        logic       e_active;
        logic [1:0] e_sel;
        logic [3:0] e_fade;
        logic       e_pause;
        logic       e_done;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_out(input string nm, input int a, input int s, input int f, input int p);
        chk({nm, ".active"}, int'(screen_active), a);
        chk({nm, ".sel"},    int'(screen_sel), s);
        chk({nm, ".fade"},   int'(fade), f);
        chk({nm, ".pause"},  int'(game_pause), p);
    endtask

    // Inputs change just after a falling edge, so the next rising edge samples them cleanly.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge vga_clk);
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_once();
            idle(9);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
        idle(1);
    endtask

    task automatic pulse_req(input logic l, input logic w, input logic t);
        lose_req  = l;
        win_req   = w;
        title_req = t;
        @(negedge vga_clk);
        lose_req  = 1'b0;
        win_req   = 1'b0;
        title_req = 1'b0;
    endtask

    // Final fade-out tick: one-cycle seq_done, overlay off, pause reflects what is still pending.
    task automatic finish_tick(input string nm, input int exp_pause);
        tick_once();
        chk({nm, ".done"}, int'(seq_done), 1);
        chk_out(nm, 0, 0, 0, exp_pause);
        @(negedge vga_clk);
        chk({nm, ".done_clr"}, int'(seq_done), 0);
        idle(8);
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; lose_req = 1'b0; win_req = 1'b0;
        title_req = 1'b0; skip = 1'b0;

        //            rst tick lose win title skp | act sel fade pause done
        vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 2'd0, 4'd0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 0,  0, 2'd0, 4'd0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0,  0, 2'd0, 4'd0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 0,  1, 2'd1, 4'd0, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0,  1, 2'd1, 4'd0, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, 0, 0,  1, 2'd1, 4'd1, 1, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 1,  1, 2'd1, 4'd1, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 0,  1, 2'd1, 4'd1, 1, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 0,  0, 2'd0, 4'd0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0, 0, 0,  0, 2'd0, 4'd0, 0, 0};
        vecs[10] = '{0, 1, 0, 1, 0, 0,  1, 2'd2, 4'd0, 1, 0};
        vecs[11] = '{1, 0, 0, 0, 0, 0,  0, 2'd0, 4'd0, 0, 0};

        @(negedge vga_clk);
        for (int i = 0; i < 12; i++) begin
            Reset = vecs[i].rst; frame_tick = vecs[i].tick; lose_req = vecs[i].lose;
            win_req = vecs[i].win; title_req = vecs[i].title; skip = vecs[i].skp;
            @(negedge vga_clk);
            chk_out($sformatf("vec%0d", i), int'(vecs[i].e_active), int'(vecs[i].e_sel),
                    int'(vecs[i].e_fade), int'(vecs[i].e_pause));
            chk($sformatf("vec%0d.done", i), int'(seq_done), int'(vecs[i].e_done));
        end
        Reset = 1'b0; frame_tick = 1'b0; win_req = 1'b0; title_req = 1'b0;
        lose_req = 1'b0; skip = 1'b0;

        // Full lose sequence: 30 fade-in, 180 hold, 30 fade-out ticks.
        do_reset();
        pulse_req(1, 0, 0);
        idle(3);
        tick_n(1);  chk_out("t1.start", 1, 3, 0, 1);
        tick_n(29); chk_out("t1.in29", 1, 3, 14, 1);
        tick_n(1);  chk_out("t1.in30", 1, 3, 15, 1);
        tick_n(179); chk_out("t1.hold179", 1, 3, 15, 1);
        tick_n(1);  chk_out("t1.hold180", 1, 3, 15, 1);
        tick_n(2);  chk_out("t1.out2", 1, 3, 14, 1);
        tick_n(27); chk_out("t1.out29", 1, 3, 1, 1);
        finish_tick("t1.end", 0);

        // Same-cycle win+title: win first, title one frame after win ends, pause held.
        do_reset();
        pulse_req(0, 1, 1);
        tick_n(1);  chk_out("t2.start", 1, 2, 0, 1);
        tick_n(239);
        finish_tick("t2.end", 1);
        tick_n(1);  chk_out("t2.title", 1, 1, 0, 1);

        // Lose preempts win during hold, then lose runs.
        do_reset();
        pulse_req(0, 1, 0);
        tick_n(31); chk_out("t3.hold", 1, 2, 15, 1);
        tick_n(3);
        pulse_req(1, 0, 0);
        idle(2);
        tick_n(1);  chk_out("t3.pre", 1, 2, 15, 1);
        tick_n(2);  chk_out("t3.out2", 1, 2, 14, 1);
        tick_n(27); chk_out("t3.out29", 1, 2, 1, 1);
        finish_tick("t3.end", 1);
        tick_n(1);  chk_out("t3.lose", 1, 3, 0, 1);

        // Skip at hold cnt=5 leaves hold on that tick.
        do_reset();
        pulse_req(0, 0, 1);
        tick_n(31);
        tick_n(5);
        skip = 1'b1;
        idle(3);
        chk_out("t4.noskip", 1, 1, 15, 1);
        tick_once();
        skip = 1'b0;
        idle(9);
        tick_n(2);  chk_out("t4.out2", 1, 1, 14, 1);
        tick_n(27); chk_out("t4.out29", 1, 1, 1, 1);

        // Reset mid fade-in clears outputs and pending.
        do_reset();
        pulse_req(1, 0, 0);
        tick_n(15); chk_out("t5.fade7", 1, 3, 7, 1);
        pulse_req(0, 1, 0);
        Reset = 1'b1;
        @(negedge vga_clk);
        chk_out("t5.rst", 0, 0, 0, 0);
        Reset = 1'b0;
        idle(2);
        tick_n(2);  chk_out("t5.nopend", 0, 0, 0, 0);

        // Long gap without frame_tick; duplicate lose during lose run.
        do_reset();
        pulse_req(1, 0, 0);
        idle(1000);
        chk_out("t6.wait", 0, 0, 0, 0);
        tick_n(1);  chk_out("t6.start", 1, 3, 0, 1);
        tick_n(35);
        pulse_req(1, 0, 0);
        idle(1);
        tick_n(204);
        finish_tick("t6.end", 0);
        tick_n(2);  chk_out("t6.once", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
